osc_wave_analyser: RTL and testbench
====================================

Name: osc_wave_analyser

Overview:
- Measures a sampled periodic waveform, e.g. the output of the triangle oscillator.
- Detects turning points (peaks and troughs) with hysteresis.
- Per cycle (peak to peak), reports the period in samples plus the max and min amplitude, over a valid/ready interface.
- Sits on the oscillator output bus, feeding the control/debug register block.

Parameters:
WAVE_WIDTH_P, 24, signed sample width
COUNTER_WIDTH_P, 32, period counter and meas_period width
HYSTERESIS_P, 0, non-negative; drop/rise beyond the running extreme (strictly greater) needed to declare a turning point

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
sample_valid  input  1  sample qualifier, e.g. the oscillator clock_enable delayed one cycle
sample  input  WAVE_WIDTH_P  signed waveform sample
meas_valid  output  1  measurement available
meas_ready  input  1  consumer accepts measurement
meas_period  output  COUNTER_WIDTH_P  samples between the last two peak detections
meas_max  output  WAVE_WIDTH_P  signed peak value
meas_min  output  WAVE_WIDTH_P  signed trough value preceding that peak
meas_overrun  output  1  at least one measurement dropped since the last accepted one

Behaviour:
- Interface: one clock, clk; reset asynchronous active-low, rst_n.
- Reset values: all outputs 0; state SEARCH_E; armed=0; cnt=0; extremes=0; overrun flag=0.
- Cycle rule: only cycles with sample_valid=1 update the detector. If sample_valid=0, detector state and counters hold.
- Comparisons are done in WAVE_WIDTH_P+1 signed, so extreme±HYSTERESIS_P cannot overflow.
- FSM states: SEARCH_E, RISING_E, FALLING_E.
- SEARCH_E:
  - First accepted sample sets ref=sample.
  - Stay while |sample-ref| <= HYSTERESIS_P.
  - sample > ref+H: go RISING_E, ext=sample.
  - sample < ref-H: go FALLING_E, ext=sample.
  - No turning point is recorded in this state.
- RISING_E:
  - sample >= ext: ext=sample.
  - sample < ext-H: peak detected; peak value=ext; go FALLING_E; ext=sample.
- FALLING_E:
  - sample <= ext: ext=sample.
  - sample > ext+H: trough detected; trough_reg=ext; go RISING_E; ext=sample.
  - Equal samples never change state.
- Period counter:
  - Each accepted non-peak sample: cnt += 1, saturating at all-ones.
  - On a peak-detect sample: period = cnt+1 (saturating), then cnt=0.
  - A saturated meas_period (all ones) means timeout.
- Arming:
  - The first peak after reset, or after leaving SEARCH_E, only sets armed=1; no measurement is produced.
  - Each later peak produces a measurement {period, peak value, trough_reg}.
- Output timing:
  - Output registers load in the cycle after the detecting sample, so meas_valid rises with latency 1.
  - Outputs hold stable while meas_valid=1 and meas_ready=0.
  - meas_valid clears the cycle after meas_valid&&meas_ready.
- Drop policy:
  - New measurement while meas_valid=1 and meas_ready=0: new measurement discarded, internal overrun flag set.
  - The next loaded measurement carries meas_overrun=1; the flag clears on load.
  - Handshake and a new load in the same cycle: accepted; the new measurement loads, no drop.
- Reset mid-operation: immediate return to reset values; any pending measurement is lost.

Optional Feature:
- Macro: OSC_ANALYSER_AMPLITUDE_EN.
- Defined: adds output port meas_amplitude, width WAVE_WIDTH_P+1, unsigned, = meas_max - meas_min. It is registered with the other meas_* outputs and follows the same valid/hold rules.
- Undefined: port and subtractor absent; all other behaviour identical.

Decomposition:
- Package osc_analyser_pkg:
  - typedef enum osc_analyser_state_t {SEARCH_E, RISING_E, FALLING_E}
  - measurement struct typedef {period, max, min, overrun}
- Sub-module osc_turning_point_detector: holds SEARCH/RISING/FALLING and the hysteresis compare. Outputs a one-cycle peak_det/trough_det pulse plus the extreme value.
- Top level holds the period counter, arming, output register and handshake.

Test Plan:
- H=0; samples 0,1,2,3,2,1,0,1,2,3,2 with meas_ready=1. First peak at index 4 only arms. Second detection at index 10 -> meas_valid one cycle later with period=6, max=3, min=0, overrun=0.
- Triangle oscillator stream -8..7 in steps of 1 (period 30 samples), H=0, continuous -> every measurement reports period=30, max=7, min=-8.
- H=2; ±1 noise spikes on a rising ramp -> no false turning points; reported period equals the clean-waveform value.
- meas_ready=0 across three peaks -> first measurement held stable, later two dropped. After ready pulses, the next measurement shows overrun=1; the one after shows overrun=0.
- Constant sample input after arming, COUNTER_WIDTH_P=8, with a drop at sample 300 -> meas_period=255 (saturated).
- rst_n asserted mid-cycle with meas_valid=1 -> meas_valid=0 immediately. After release, the first peak only arms.

Source files
------------

// File: rtl/osc_analyser_pkg.sv
// Shared types for the waveform analyser slice.
// Provides the turning-point detector state encoding.
package osc_analyser_pkg;

    typedef enum logic [1:0] {
        SEARCH_E,
        RISING_E,
        FALLING_E
    } osc_analyser_state_t;

endpackage

// File: rtl/osc_wave_analyser_if.sv
// Measurement bus from the waveform analyser to its consumer.
// Ports: meas_valid/meas_ready handshake, meas_period, meas_max,
//   meas_min, meas_overrun; meas_amplitude only when
//   OSC_ANALYSER_AMPLITUDE_EN is defined.
// Modports: master (analyser side), slave (consumer side).
interface osc_wave_analyser_if #(
    parameter int WAVE_WIDTH_P    = 24,
    parameter int COUNTER_WIDTH_P = 32
);
    import osc_analyser_pkg::*;

    logic                              meas_valid;
    logic                              meas_ready;
    logic        [COUNTER_WIDTH_P-1:0] meas_period;
    logic signed [WAVE_WIDTH_P-1:0]    meas_max;
    logic signed [WAVE_WIDTH_P-1:0]    meas_min;
    logic                              meas_overrun;
`ifdef OSC_ANALYSER_AMPLITUDE_EN
    logic        [WAVE_WIDTH_P:0]      meas_amplitude;

    modport master (
        output meas_valid, meas_period, meas_max,
        output meas_min, meas_overrun, meas_amplitude,
        input  meas_ready
    );
    modport slave (
        input  meas_valid, meas_period, meas_max,
        input  meas_min, meas_overrun, meas_amplitude,
        output meas_ready
    );
`else
    modport master (
        output meas_valid, meas_period, meas_max,
        output meas_min, meas_overrun,
        input  meas_ready
    );
    modport slave (
        input  meas_valid, meas_period, meas_max,
        input  meas_min, meas_overrun,
        output meas_ready
    );
`endif

endinterface

// File: rtl/osc_turning_point_detector.sv
// Peak/trough detector with hysteresis on a qualified sample stream.
// Ports: clk, rst_n, sample_valid, sample in; peak_det/trough_det
//   single-cycle pulses (combinational on the detecting sample) and
//   extreme, the running extreme before that sample is applied.
module osc_turning_point_detector
    import osc_analyser_pkg::*;
#(
    parameter int WAVE_WIDTH_P = 24,
    parameter int HYSTERESIS_P = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_valid,
    input  logic signed [WAVE_WIDTH_P-1:0] sample,
    output logic                           peak_det,
    output logic                           trough_det,
    output logic signed [WAVE_WIDTH_P-1:0] extreme
);

    localparam int XW = WAVE_WIDTH_P + 1;
    localparam logic signed [XW-1:0] HYST = XW'(HYSTERESIS_P);

    osc_analyser_state_t state_q, state_d;
    logic signed [WAVE_WIDTH_P-1:0] ext_q, ext_d;
    logic ref_ok_q, ref_ok_d;

    // One extra bit so ext +/- HYST cannot wrap.
    logic signed [XW-1:0] s_x, e_x, hi_x, lo_x;

    always_comb begin
        s_x  = {sample[WAVE_WIDTH_P-1], sample};
        e_x  = {ext_q[WAVE_WIDTH_P-1], ext_q};
        hi_x = e_x + HYST;
        lo_x = e_x - HYST;

        state_d    = state_q;
        ext_d      = ext_q;
        ref_ok_d   = ref_ok_q;
        peak_det   = 1'b0;
        trough_det = 1'b0;

        if (sample_valid) begin
            unique case (state_q)
                // ext_q doubles as the reference while searching.
                SEARCH_E: begin
                    if (!ref_ok_q) begin
                        ext_d    = sample;
                        ref_ok_d = 1'b1;
                    end else if (s_x > hi_x) begin
                        state_d = RISING_E;
                        ext_d   = sample;
                    end else if (s_x < lo_x) begin
                        state_d = FALLING_E;
                        ext_d   = sample;
                    end
                end
                RISING_E: begin
                    if (s_x >= e_x) begin
                        ext_d = sample;
                    end else if (s_x < lo_x) begin
                        peak_det = 1'b1;
                        state_d  = FALLING_E;
                        ext_d    = sample;
                    end
                end
                FALLING_E: begin
                    if (s_x <= e_x) begin
                        ext_d = sample;
                    end else if (s_x > hi_x) begin
                        trough_det = 1'b1;
                        state_d    = RISING_E;
                        ext_d      = sample;
                    end
                end
                default: state_d = SEARCH_E;
            endcase
        end
    end

    assign extreme = ext_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH_E;
            ext_q    <= '0;
            ref_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            ref_ok_q <= ref_ok_d;
        end
    end

endmodule

// File: rtl/osc_wave_analyser.sv
// Per-cycle period/peak/trough measurement of a sampled waveform.
// Ports: clk, rst_n, sample_valid, sample; meas (master modport of
//   osc_wave_analyser_if) carrying the valid/ready measurement.
// Optional: OSC_ANALYSER_AMPLITUDE_EN adds meas_amplitude = max - min.
module osc_wave_analyser
    import osc_analyser_pkg::*;
#(
    parameter int WAVE_WIDTH_P    = 24,
    parameter int COUNTER_WIDTH_P = 32,
    parameter int HYSTERESIS_P    = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_valid,
    input  logic signed [WAVE_WIDTH_P-1:0] sample,
    osc_wave_analyser_if.master            meas
);

    typedef struct packed {
        logic        [COUNTER_WIDTH_P-1:0] period;
        logic signed [WAVE_WIDTH_P-1:0]    peak;
        logic signed [WAVE_WIDTH_P-1:0]    trough;
        logic                              overrun;
    } meas_t;

    localparam logic [COUNTER_WIDTH_P-1:0] CNT_MAX = '1;

    logic                           peak_det;
    logic                           trough_det;
    logic signed [WAVE_WIDTH_P-1:0] extreme;

    osc_turning_point_detector #(
        .WAVE_WIDTH_P (WAVE_WIDTH_P),
        .HYSTERESIS_P (HYSTERESIS_P)
    ) u_detector (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .peak_det     (peak_det),
        .trough_det   (trough_det),
        .extreme      (extreme)
    );

    meas_t                          out_q, out_d;
    logic                           valid_q, valid_d;
    logic                           armed_q, armed_d;
    logic                           drop_q, drop_d;
    logic [COUNTER_WIDTH_P-1:0]     cnt_q, cnt_d;
    logic [COUNTER_WIDTH_P-1:0]     period_new;
    logic signed [WAVE_WIDTH_P-1:0] trough_q, trough_d;
    logic                           new_meas;
`ifdef OSC_ANALYSER_AMPLITUDE_EN
    logic [WAVE_WIDTH_P:0]          amp_q, amp_d;
`endif

    always_comb begin
        period_new = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

        cnt_d    = cnt_q;
        armed_d  = armed_q;
        trough_d = trough_q;
        out_d    = out_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
`ifdef OSC_ANALYSER_AMPLITUDE_EN
        amp_d    = amp_q;
`endif

        if (sample_valid) begin
            if (peak_det) begin
                cnt_d   = '0;
                armed_d = 1'b1;
            end else begin
                cnt_d = period_new;
            end
            if (trough_det) begin
                trough_d = extreme;
            end
        end

        new_meas = sample_valid && peak_det && armed_q;

        if (valid_q && meas.meas_ready) begin
            valid_d = 1'b0;
        end

        // A slot frees up in the same cycle it is handed off.
        if (new_meas) begin
            if (!valid_q || meas.meas_ready) begin
                valid_d       = 1'b1;
                out_d.period  = period_new;
                out_d.peak    = extreme;
                out_d.trough  = trough_q;
                out_d.overrun = drop_q;
                drop_d        = 1'b0;
`ifdef OSC_ANALYSER_AMPLITUDE_EN
                amp_d = {extreme[WAVE_WIDTH_P-1], extreme}
                      - {trough_q[WAVE_WIDTH_P-1], trough_q};
`endif
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            valid_q  <= 1'b0;
            armed_q  <= 1'b0;
            drop_q   <= 1'b0;
            cnt_q    <= '0;
            trough_q <= '0;
`ifdef OSC_ANALYSER_AMPLITUDE_EN
            amp_q    <= '0;
`endif
        end else begin
            out_q    <= out_d;
            valid_q  <= valid_d;
            armed_q  <= armed_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            trough_q <= trough_d;
`ifdef OSC_ANALYSER_AMPLITUDE_EN
            amp_q    <= amp_d;
`endif
        end
    end

    assign meas.meas_valid   = valid_q;
    assign meas.meas_period  = out_q.period;
    assign meas.meas_max     = out_q.peak;
    assign meas.meas_min     = out_q.trough;
    assign meas.meas_overrun = out_q.overrun;
`ifdef OSC_ANALYSER_AMPLITUDE_EN
    assign meas.meas_amplitude = amp_q;
`endif

endmodule

// File: tb/tb_osc_wave_analyser.sv
// Scoreboard bench for osc_wave_analyser.
// dut0: H=0, 8-bit counter. dut1: H=2, 32-bit counter.
module tb_osc_wave_analyser;

    typedef struct {
        longint period;
        longint mx;
        longint mn;
        longint ovr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sv0, sv1;
    logic signed [23:0] s0, s1;

    osc_wave_analyser_if #(.WAVE_WIDTH_P(24), .COUNTER_WIDTH_P(8))  if0 ();
    osc_wave_analyser_if #(.WAVE_WIDTH_P(24), .COUNTER_WIDTH_P(32)) if1 ();

    osc_wave_analyser #(
        .WAVE_WIDTH_P(24), .COUNTER_WIDTH_P(8), .HYSTERESIS_P(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv0),
        .sample(s0), .meas(if0)
    );

    osc_wave_analyser #(
        .WAVE_WIDTH_P(24), .COUNTER_WIDTH_P(32), .HYSTERESIS_P(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv1),
        .sample(s1), .meas(if1)
    );

    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    function automatic void chk(string name, longint got, longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endfunction

    function automatic exp_t mk(longint p, longint mx, longint mn, longint o);
        exp_t e;
        e.period = p;
        e.mx = mx;
        e.mn = mn;
        e.ovr = o;
        return e;
    endfunction

    // Monitor dut0: hold stability and scoreboard pop on handshake.
    initial begin : mon0
        bit hold;
        longint sp, smx, smn, so;
        exp_t e;
        hold = 0;
        sp = 0; smx = 0; smn = 0; so = 0;
        forever begin
            @(negedge clk);
            if (if0.meas_valid && hold) begin
                chk("dut0 hold period", longint'(if0.meas_period), sp);
                chk("dut0 hold max", longint'($signed(if0.meas_max)), smx);
                chk("dut0 hold min", longint'($signed(if0.meas_min)), smn);
                chk("dut0 hold overrun", longint'(if0.meas_overrun), so);
            end
            hold = if0.meas_valid && !if0.meas_ready;
            sp  = longint'(if0.meas_period);
            smx = longint'($signed(if0.meas_max));
            smn = longint'($signed(if0.meas_min));
            so  = longint'(if0.meas_overrun);
            if (if0.meas_valid && if0.meas_ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut0 unexpected meas: period %0d, none expected", sp);
                end else begin
                    e = q0.pop_front();
                    chk("dut0 period", sp, e.period);
                    chk("dut0 max", smx, e.mx);
                    chk("dut0 min", smn, e.mn);
                    chk("dut0 overrun", so, e.ovr);
                end
            end
        end
    end

    initial begin : mon1
        bit hold;
        longint sp, smx, smn, so;
        exp_t e;
        hold = 0;
        sp = 0; smx = 0; smn = 0; so = 0;
        forever begin
            @(negedge clk);
            if (if1.meas_valid && hold) begin
                chk("dut1 hold period", longint'(if1.meas_period), sp);
                chk("dut1 hold max", longint'($signed(if1.meas_max)), smx);
            end
            hold = if1.meas_valid && !if1.meas_ready;
            sp  = longint'(if1.meas_period);
            smx = longint'($signed(if1.meas_max));
            smn = longint'($signed(if1.meas_min));
            so  = longint'(if1.meas_overrun);
            if (if1.meas_valid && if1.meas_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut1 unexpected meas: period %0d, none expected", sp);
                end else begin
                    e = q1.pop_front();
                    chk("dut1 period", sp, e.period);
                    chk("dut1 max", smx, e.mx);
                    chk("dut1 min", smn, e.mn);
                    chk("dut1 overrun", so, e.ovr);
                end
            end
        end
    end

    task automatic send0(input int v);
        @(posedge clk);
        #1;
        s0 = 24'(v);
        sv0 = 1'b1;
    endtask

    task automatic idle0();
        @(posedge clk);
        #1;
        sv0 = 1'b0;
    endtask

    task automatic send1(input int v);
        @(posedge clk);
        #1;
        s1 = 24'(v);
        sv1 = 1'b1;
    endtask

    // Triangle -8..7, period 30; continues from tv/tup.
    int tv = 2;
    bit tup = 0;

    task automatic tri_peaks0(input int k);
        int n = 0;
        while (n < k) begin
            if (tup) begin
                if (tv == 7) begin
                    tup = 0;
                    tv = 6;
                    n++;
                end else begin
                    tv++;
                end
            end else begin
                if (tv == -8) begin
                    tup = 1;
                    tv = -7;
                end else begin
                    tv--;
                end
            end
            send0(tv);
        end
    endtask

    int t1[11] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};

    task automatic run_t1();
        for (int i = 0; i < 11; i++) begin
            send0(t1[i]);
            if (i == 10) chk("latency pre valid", longint'(if0.meas_valid), 0);
        end
        idle0();
        chk("latency valid", longint'(if0.meas_valid), 1);
        repeat (3) idle0();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int v, k;
        rst_n = 1'b0;
        sv0 = 1'b0; sv1 = 1'b0;
        s0 = '0; s1 = '0;
        if0.meas_ready = 1'b1;
        if1.meas_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid0", longint'(if0.meas_valid), 0);
        chk("reset period0", longint'(if0.meas_period), 0);
        chk("reset max0", longint'($signed(if0.meas_max)), 0);
        chk("reset min0", longint'($signed(if0.meas_min)), 0);
        chk("reset overrun0", longint'(if0.meas_overrun), 0);
        chk("reset valid1", longint'(if1.meas_valid), 0);
        chk("reset period1", longint'(if1.meas_period), 0);
        rst_n = 1'b1;

        // First peak arms, second reports.
        q0.push_back(mk(6, 3, 0, 0));
        run_t1();

        // Continuous triangle; first one starts mid-descent.
        q0.push_back(mk(26, 7, -8, 0));
        q0.push_back(mk(30, 7, -8, 0));
        q0.push_back(mk(30, 7, -8, 0));
        tri_peaks0(3);
        repeat (3) idle0();

        // Backpressure across three peaks.
        if0.meas_ready = 1'b0;
        q0.push_back(mk(30, 7, -8, 0));
        tri_peaks0(3);
        repeat (2) idle0();
        chk("held valid", longint'(if0.meas_valid), 1);
        if0.meas_ready = 1'b1;
        idle0();
        q0.push_back(mk(30, 7, -8, 1));
        q0.push_back(mk(30, 7, -8, 0));
        tri_peaks0(2);
        repeat (3) idle0();

        // Long flat stretch saturates the 8-bit period.
        q0.push_back(mk(255, 1, 0, 0));
        repeat (300) send0(0);
        send0(1);
        send0(0);
        repeat (3) idle0();

        // Reset while a measurement is pending.
        if0.meas_ready = 1'b0;
        send0(1);
        send0(0);
        idle0();
        chk("pre-reset valid", longint'(if0.meas_valid), 1);
        chk("pre-reset period", longint'(if0.meas_period), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset valid", longint'(if0.meas_valid), 0);
        chk("async reset period", longint'(if0.meas_period), 0);
        chk("async reset max", longint'($signed(if0.meas_max)), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if0.meas_ready = 1'b1;
        q0.push_back(mk(6, 3, 0, 0));
        run_t1();

        // Noisy rising ramp, H=2.
        q1.push_back(mk(30, 15, 0, 0));
        q1.push_back(mk(30, 15, 0, 0));
        for (int i = 0; i < 100; i++) begin
            k = i % 30;
            v = (k <= 15) ? k : 30 - k;
            if (k >= 3 && k <= 11) begin
                if (k % 3 == 0) v = v + 1;
                else if (k % 3 == 1) v = v - 1;
            end
            send1(v);
        end
        @(posedge clk);
        #1;
        sv1 = 1'b0;

        for (int i = 0; i < 50; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("dut0 queue drained", longint'(q0.size()), 0);
        chk("dut1 queue drained", longint'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
